// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg: shared definitions for the sequential divider.
//   DIV_WIDTH : default operand/result width (iteration count equals width)
//   state_e   : divider FSM encoding, also exported on the debug state port
package div32_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/div32_seq_step.sv
// div32_seq_step: one combinational restoring-division step.
//   rem_in  : partial remainder, always < dvs on entry
//   dvd_msb : next dividend bit shifted into the remainder
//   dvs     : divisor magnitude
//   rem_out : partial remainder after the trial subtraction
//   q_bit   : quotient bit produced by this step
module div32_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // The shifted remainder keeps rem_in's MSB: with a divisor above
    // 2^(WIDTH-1) the remainder can legitimately have its top bit set.
    // Because rem_in < dvs, rem_sh - dvs lies in (-2^WIDTH, 2^WIDTH), so
    // bit WIDTH of the difference is a reliable borrow/sign bit.
    always_comb begin
        rem_sh  = {rem_in, dvd_msb};
        trial   = rem_sh - {1'b0, dvs};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider for DIV/DIVU, one quotient bit
// per clock.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, sampled only in IDLE
//   sign_mode    : 1 signed (DIV), 0 unsigned (DIVU)
//   a, b         : dividend, divisor
//   busy         : high in PREP/ITER/FIX
//   done         : one-cycle pulse, results valid from this cycle
//   q, r         : quotient / remainder, held until overwritten at next done
//   div_zero     : divisor was zero
//   overflow     : signed most-negative / -1
//   dbg_state    : current FSM state
// Handshake: start is a single-cycle request accepted only while idle;
// requests at any other time (including the done cycle) are dropped.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             overflow,
    output state_e           dbg_state
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend, then quotient as bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;

    div32_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        q_d        = q_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d      = a;
                    dvs_d      = b;
                    sign_d     = sign_mode;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = ST_PREP;
                end
            end
            ST_PREP: begin
                if (dvs_q == '0) begin
                    q_d        = '1;
                    r_d        = dvd_q;
                    div_zero_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (sign_q && dvd_q == MOST_NEG && dvs_q == '1) begin
                    q_d        = MOST_NEG;
                    r_d        = '0;
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // Iterate on magnitudes; signs are restored in FIX.
                    dvd_d   = (sign_q && dvd_q[WIDTH-1]) ? (~dvd_q + 1'b1) : dvd_q;
                    dvs_d   = (sign_q && dvs_q[WIDTH-1]) ? (~dvs_q + 1'b1) : dvs_q;
                    rem_d   = '0;
                    cnt_d   = CNT_LAST;
                    q_neg_d = sign_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_d = sign_q & dvd_q[WIDTH-1];
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                q_d     = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
                r_d     = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            q_q        <= q_d;
            r_q        <= r_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy      = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
    assign done      = (state_q == ST_DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div32_seq.sv
module tb_div32_seq;
  import div32_seq_pkg::*;

  localparam int W        = 32;
  localparam int LAT_NORM = W + 3;  // cycles from the start cycle to the done cycle
  localparam int BUSY_NRM = W + 2;
  localparam int LAT_SHRT = 2;
  localparam int BUSY_SHR = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sign_mode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic          div_zero;
  logic          overflow;
  state_e        dbg_state;

  int n_vec = 0;
  int n_err = 0;

  div32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_mode (sign_mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: one request, waits (bounded) for done; operands are scrambled
  // right after acceptance to show they are not sampled again.
  task automatic run_div(input logic sgn, input logic [W-1:0] va, input logic [W-1:0] vb,
                         output int lat, output int bcnt);
    bit got;
    @(negedge clk);
    start = 1'b1; sign_mode = sgn; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom(); b = $urandom(); sign_mode = ~sgn;
    lat = 0; bcnt = 0; got = 0;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        got = 1;
        break;
      end
    end
    if (!got) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    string      name;
    logic       sgn;
    logic [31:0] va, vb, eq, er;
    logic       edz, eov;
    int         elat, ebusy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, bcnt, n_done;
    logic [31:0] cap_q, cap_r;

    vecs[0]  = '{"u100_7",    1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[1]  = '{"s_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[2]  = '{"s_7_m2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[3]  = '{"u_dz",      1'b0, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, LAT_SHRT, BUSY_SHR};
    vecs[4]  = '{"s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[5]  = '{"s_dz",      1'b1, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, LAT_SHRT, BUSY_SHR};
    vecs[6]  = '{"s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, LAT_SHRT, BUSY_SHR};
    vecs[7]  = '{"u_minneg",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[8]  = '{"u_bigdvs",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[9]  = '{"s_min_2",   1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 1'b0, LAT_NORM, BUSY_NRM};
    vecs[10] = '{"u_1000_33", 1'b0, 32'd1000,     32'd33,       32'd30,       32'd10,       1'b0, 1'b0, LAT_NORM, BUSY_NRM};

    rst = 1'b1; start = 1'b0; sign_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",  {31'd0, busy},     32'd0);
    check_val("rst_done",  {31'd0, done},     32'd0);
    check_val("rst_q",     q,                 32'd0);
    check_val("rst_r",     r,                 32'd0);
    check_val("rst_dz",    {31'd0, div_zero}, 32'd0);
    check_val("rst_ovf",   {31'd0, overflow}, 32'd0);
    check_val("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_div(vecs[i].sgn, vecs[i].va, vecs[i].vb, lat, bcnt);
      check_val({vecs[i].name, "_q"},    q,                 vecs[i].eq);
      check_val({vecs[i].name, "_r"},    r,                 vecs[i].er);
      check_val({vecs[i].name, "_dz"},   {31'd0, div_zero}, {31'd0, vecs[i].edz});
      check_val({vecs[i].name, "_ovf"},  {31'd0, overflow}, {31'd0, vecs[i].eov});
      check_val({vecs[i].name, "_lat"},  lat,               vecs[i].elat);
      check_val({vecs[i].name, "_busy"}, bcnt,              vecs[i].ebusy);
      @(negedge clk);
      check_val({vecs[i].name, "_pulse"}, {31'd0, done}, 32'd0);
      check_val({vecs[i].name, "_hold"},  q,             vecs[i].eq);
    end

    // second start while busy, then a start in the done cycle: both dropped
    @(negedge clk);
    start = 1'b1; sign_mode = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0; cap_q = '0; cap_r = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        cap_q = q; cap_r = r;
        start = 1'b1; a = 32'd5; b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_val("donecyc_start_busy", {31'd0, busy}, 32'd0);
      end
    end
    check_val("busy_start_ndone", n_done, 32'd1);
    check_val("busy_start_q",     cap_q,  32'd14);
    check_val("busy_start_r",     cap_r,  32'd2);

    // reset in the middle of the iterations
    @(negedge clk);
    start = 1'b1; sign_mode = 1'b0; a = 32'hFFFF; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    check_val("midrst_q",    q,             32'd0);
    check_val("midrst_r",    r,             32'd0);
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("midrst_nodone", n_done, 32'd0);

    run_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, bcnt);
    check_val("post_rst_q",   q,   32'hFFFFFFFF);
    check_val("post_rst_r",   r,   32'd0);
    check_val("post_rst_lat", lat, LAT_NORM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
